// File: rtl/mem_bus_bridge.sv
// Bridges core loads/stores onto a single-master request/grant bus, using a small posted-write FIFO.
// Optional macro BUS_TIMEOUT_EN adds a bus-wait watchdog that aborts with a bus_err pulse.
module mem_bus_bridge #(
  parameter int unsigned WBUF_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        mem_rw_mode,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  input  logic [3:0]  mem_byte_en,
  input  logic        rd_req,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        wbuf_empty,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_DATA} state_t;

  state_t        state;
  logic [29:0]   fifo_addr [WBUF_DEPTH];
  logic [31:0]   fifo_data [WBUF_DEPTH];
  logic [3:0]    fifo_be   [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_req;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          timeout;

  assign wr_req = !mem_rw_mode && (mem_byte_en != 4'h0);
  assign full   = (count == CW'(WBUF_DEPTH));
  assign empty  = (count == '0);
  // Fullness is judged before this cycle's pop, so a full buffer never takes a push.
  assign push   = wr_req && !full;
  assign pop    = (state == WR) && (bus_gnt || timeout);

  assign busy       = (wr_req && full) || (rd_req && !rd_valid);
  assign wbuf_empty = empty && (state != WR);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= mem_addr[31:2];
      fifo_data[wr_ptr] <= mem_write_data;
      fifo_be[wr_ptr]   <= mem_byte_en;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Cleared in IDLE and on the RD_ADDR->RD_DATA hop, so each bus state gets a fresh budget.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || timeout || (state == RD_ADDR && bus_gnt)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign timeout = (state != IDLE) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          // Buffered writes always go first; the rd_valid guard stops a held rd_req re-issuing.
          if (!empty) begin
            state     <= WR;
            bus_req   <= 1'b1;
            bus_we    <= 1'b1;
            bus_addr  <= {fifo_addr[rd_ptr], 2'b00};
            bus_wdata <= fifo_data[rd_ptr];
            bus_be    <= fifo_be[rd_ptr];
          end else if (rd_req && !wr_req && !rd_valid) begin
            state     <= RD_ADDR;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_wdata <= '0;
            bus_be    <= 4'hF;
          end
        end
        WR: begin
          if (bus_gnt) begin
            state   <= IDLE;
            bus_req <= 1'b0;
          end else if (timeout) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_err <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (bus_gnt) begin
            state   <= RD_DATA;
            bus_req <= 1'b0;
          end else if (timeout) begin
            state    <= IDLE;
            bus_req  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b1;
            bus_err  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (bus_rvalid) begin
            state    <= IDLE;
            rd_data  <= bus_rdata;
            rd_valid <= 1'b1;
          end else if (timeout) begin
            state    <= IDLE;
            rd_data  <= '0;
            rd_valid <= 1'b1;
            bus_err  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: a cycle table for write/read flow plus hand sequences
// for back-pressure, push/pop overlap, pointer wrap, async reset and (with BUS_TIMEOUT_EN) the watchdog.
module tb_mem_bus_bridge;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        mem_rw_mode = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic [3:0]  mem_byte_en = '0;
  logic        rd_req = 1'b0;
  logic        busy;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wbuf_empty;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 i_clk = ~i_clk;

  mem_bus_bridge #(.WBUF_DEPTH(2), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .mem_rw_mode(mem_rw_mode), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_byte_en(mem_byte_en), .rd_req(rd_req),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .wbuf_empty(wbuf_empty), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  int errors = 0;
  int checks = 0;

  logic [63:0] granted[$];

  always @(negedge i_clk) begin
    if (i_rst && bus_req && bus_gnt && bus_we) granted.push_back({bus_addr, bus_wdata});
  end

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rd;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic        e_empty;
    logic        e_busy;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_rw_mode    = 1'b1;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_byte_en    = 4'h0;
    rd_req         = 1'b0;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_rw_mode    = 1'b0;
    mem_addr       = a;
    mem_write_data = d;
    mem_byte_en    = be;
  endtask

  // Hold the write until the bridge accepts it, then release.
  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    n = 0;
    drive_write(a, d, be);
    #1;
    while (busy && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail_bound("push_write_busy");
    step();
    drive_idle();
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (!wbuf_empty && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail_bound(name);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b0, 32'h1003, 32'hA5A51234, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0,    32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                 1'b1, 1'b1, 32'h1000, 32'hA5A51234, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0,    32'h0,        4'h0, 1'b0, 1'b1, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h1000, 32'hA5A51234, 4'hF, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h20,   32'h11112222, 4'h3, 1'b0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h1000, 32'hA5A51234, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h24,   32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                 1'b1, 1'b1, 32'h20,   32'h11112222, 4'h3, 1'b0, 32'h0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 32'h24,   32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h20,   32'h11112222, 4'h3, 1'b0, 32'h0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 32'h24,   32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h24,   32'h0,        4'hF, 1'b0, 32'h0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 32'h24,   32'h0,        4'h0, 1'b1, 1'b1, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h24,   32'h0,        4'hF, 1'b0, 32'h0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 32'h24,   32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h24,   32'h0,        4'hF, 1'b0, 32'h0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 32'h24,   32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h24,   32'h0,        4'hF, 1'b0, 32'h0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 32'h24,   32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D,
                 1'b0, 1'b0, 32'h24,   32'h0,        4'hF, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h24,   32'h0,        4'hF, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 32'h0,    32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 32'h12345678,
                 1'b0, 1'b0, 32'h24,   32'h0,        4'hF, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0};

    // Asynchronous reset, checked before any clock edge.
    #3 i_rst = 1'b0;
    #1;
    check("rst_bus_req",    32'(bus_req),    32'h0);
    check("rst_bus_we",     32'(bus_we),     32'h0);
    check("rst_bus_addr",   bus_addr,        32'h0);
    check("rst_bus_wdata",  bus_wdata,       32'h0);
    check("rst_bus_be",     32'(bus_be),     32'h0);
    check("rst_rd_data",    rd_data,         32'h0);
    check("rst_rd_valid",   32'(rd_valid),   32'h0);
    check("rst_bus_err",    32'(bus_err),    32'h0);
    check("rst_wbuf_empty", 32'(wbuf_empty), 32'h1);
    check("rst_busy",       32'(busy),       32'h0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      mem_rw_mode    = vecs[i].rw;
      mem_addr       = vecs[i].addr;
      mem_write_data = vecs[i].wdata;
      mem_byte_en    = vecs[i].be;
      rd_req         = vecs[i].rd;
      bus_gnt        = vecs[i].gnt;
      bus_rvalid     = vecs[i].rvalid;
      bus_rdata      = vecs[i].rdata;
      step();
      check($sformatf("v%0d_bus_req", i),    32'(bus_req),    32'(vecs[i].e_req));
      check($sformatf("v%0d_bus_we", i),     32'(bus_we),     32'(vecs[i].e_we));
      check($sformatf("v%0d_bus_addr", i),   bus_addr,        vecs[i].e_addr);
      check($sformatf("v%0d_bus_wdata", i),  bus_wdata,       vecs[i].e_wdata);
      check($sformatf("v%0d_bus_be", i),     32'(bus_be),     32'(vecs[i].e_be));
      check($sformatf("v%0d_rd_valid", i),   32'(rd_valid),   32'(vecs[i].e_rv));
      check($sformatf("v%0d_rd_data", i),    rd_data,         vecs[i].e_rdata);
      check($sformatf("v%0d_wbuf_empty", i), 32'(wbuf_empty), 32'(vecs[i].e_empty));
      check($sformatf("v%0d_busy", i),       32'(busy),       32'(vecs[i].e_busy));
    end
    drive_idle();
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    step();

    // Three back-to-back writes into a depth-2 buffer with the bus withholding grant.
    granted.delete();
    drive_write(32'h100, 32'hD0000001, 4'hF);
    step();
    drive_write(32'h104, 32'hD0000002, 4'hF);
    step();
    drive_write(32'h108, 32'hD0000003, 4'hF);
    #1;
    check("b2b_busy_third", 32'(busy), 32'h1);
    repeat (3) step();
    check("b2b_busy_held", 32'(busy), 32'h1);
    check("b2b_req_held", 32'(bus_req), 32'h1);
    check("b2b_addr_stable", bus_addr, 32'h100);
    bus_gnt = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      step();
      n++;
    end
    check("b2b_release_cycles", 32'(n), 32'd1);
    step();
    drive_idle();
    wait_empty("b2b_drain");
    bus_gnt = 1'b0;
    step();
    check("b2b_count", 32'(granted.size()), 32'd3);
    if (granted.size() == 3) begin
      check("b2b_w0", granted[0][63:32], 32'h100);
      check("b2b_d0", granted[0][31:0],  32'hD0000001);
      check("b2b_w1", granted[1][63:32], 32'h104);
      check("b2b_d1", granted[1][31:0],  32'hD0000002);
      check("b2b_w2", granted[2][63:32], 32'h108);
      check("b2b_d2", granted[2][31:0],  32'hD0000003);
    end

    // Push and pop on the same edge with one entry buffered.
    drive_write(32'h200, 32'hE0000000, 4'h1);
    step();
    drive_idle();
    step();
    check("pp_req_a", 32'(bus_req), 32'h1);
    check("pp_addr_a", bus_addr, 32'h200);
    drive_write(32'h204, 32'hE0000001, 4'h2);
    bus_gnt = 1'b1;
    step();
    drive_idle();
    check("pp_req_gap", 32'(bus_req), 32'h0);
    check("pp_not_empty", 32'(wbuf_empty), 32'h0);
    step();
    check("pp_req_b", 32'(bus_req), 32'h1);
    check("pp_addr_b", bus_addr, 32'h204);
    check("pp_be_b", 32'(bus_be), 32'h2);
    step();
    check("pp_empty", 32'(wbuf_empty), 32'h1);
    bus_gnt = 1'b0;
    step();

    // Five writes with grant always available: order must survive pointer wrap.
    granted.delete();
    bus_gnt = 1'b1;
    for (int i = 0; i < 5; i++) push_write(32'h300 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
    wait_empty("wrap_drain");
    bus_gnt = 1'b0;
    step();
    check("wrap_count", 32'(granted.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < granted.size()) begin
        check($sformatf("wrap_addr%0d", i), granted[i][63:32], 32'h300 + 32'(4 * i));
        check($sformatf("wrap_data%0d", i), granted[i][31:0],  32'hC0DE0000 + 32'(i));
      end
    end

    // Reset while a write waits for grant: request and buffered entry vanish at once.
    push_write(32'h400, 32'h44444444, 4'hF);
    step();
    check("rwr_req_before", 32'(bus_req), 32'h1);
    check("rwr_empty_before", 32'(wbuf_empty), 32'h0);
    #2 i_rst = 1'b0;
    #1;
    check("rwr_req", 32'(bus_req), 32'h0);
    check("rwr_empty", 32'(wbuf_empty), 32'h1);
    check("rwr_addr", bus_addr, 32'h0);
    @(negedge i_clk) i_rst = 1'b1;
    step();
    step();
    check("rwr_no_replay", 32'(bus_req), 32'h0);

    // Reset during RD_DATA, then a late rvalid must not produce rd_valid.
    mem_rw_mode = 1'b1;
    mem_addr = 32'h502;
    rd_req = 1'b1;
    step();
    check("rrd_req_addr", 32'(bus_req), 32'h1);
    check("rrd_addr", bus_addr, 32'h500);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check("rrd_req_data", 32'(bus_req), 32'h0);
    #2 i_rst = 1'b0;
    rd_req = 1'b0;
    #1;
    check("rrd_req", 32'(bus_req), 32'h0);
    check("rrd_valid", 32'(rd_valid), 32'h0);
    check("rrd_empty", 32'(wbuf_empty), 32'h1);
    check("rrd_data", rd_data, 32'h0);
    @(negedge i_clk) i_rst = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    step();
    check("rrd_stale_valid1", 32'(rd_valid), 32'h0);
    step();
    check("rrd_stale_valid2", 32'(rd_valid), 32'h0);
    check("rrd_stale_data", rd_data, 32'h0);
    bus_rvalid = 1'b0;
    drive_idle();
    step();

`ifdef BUS_TIMEOUT_EN
    // Write never granted: watchdog aborts after 8 cycles in WR and discards the entry.
    push_write(32'h600, 32'h66666666, 4'hF);
    n = 0;
    begin : tmo_wait
      for (int k = 0; k < 30; k++) begin
        step();
        if (bus_err) disable tmo_wait;
        if (bus_req) n++;
      end
      fail_bound("tmo_err_wait");
    end
    check("tmo_wr_cycles", 32'(n), 32'd8);
    check("tmo_req", 32'(bus_req), 32'h0);
    check("tmo_empty", 32'(wbuf_empty), 32'h1);
    step();
    check("tmo_err_pulse", 32'(bus_err), 32'h0);
    check("tmo_no_retry", 32'(bus_req), 32'h0);
`else
    check("no_tmo_err", 32'(bus_err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 2, write-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, bus wait limit in cycles.
REQ-003 SHALL have ports: i_clk input 1, clock; i_rst input 1, reset (asynchronous, active-low).
REQ-004 SHALL have ports: mem_rw_mode input 1 (1=read, 0=write); mem_addr input 32; mem_write_data input 32; mem_byte_en input 4; rd_req input 1, load request.
REQ-005 SHALL have ports: busy output 1, stall to core; rd_data output 32; rd_valid output 1; wbuf_empty output 1; bus_err output 1.
REQ-006 SHALL have bus ports: bus_req output 1; bus_we output 1; bus_addr output 32; bus_wdata output 32; bus_be output 4; bus_gnt input 1; bus_rvalid input 1; bus_rdata input 32.

Function
REQ-007 Write request = mem_rw_mode==0 and mem_byte_en!=0; SHALL push {word address, data, byte_en} into the FIFO at the clock edge when the FIFO is not full.
REQ-008 Word address SHALL be {mem_addr[31:2],2'b00}; data and byte_en stored unmodified.
REQ-009 busy SHALL be combinational: 1 when (write request and FIFO full) or (rd_req and rd_valid==0); requester holds request while busy.
REQ-010 A full FIFO SHALL NOT accept a push even in a cycle where it pops.
REQ-011 FSM states: IDLE, WR, RD_ADDR, RD_DATA.
REQ-012 IDLE -> WR when FIFO not empty; latches head entry onto bus_addr/bus_wdata/bus_be, bus_we=1.
REQ-013 IDLE -> RD_ADDR only when FIFO empty and rd_req=1 and not mem_rw_mode==0 write; latches word address, bus_we=0, bus_be=4'hF, bus_wdata=0.
REQ-014 Writes SHALL drain before any read is issued (program order; no forwarding).
REQ-015 bus_req SHALL be 1 exactly in WR and RD_ADDR; bus_addr/bus_we/bus_wdata/bus_be stable while bus_req=1.
REQ-016 WR: on edge with bus_gnt=1 pop FIFO, -> IDLE. Latency push-edge to bus_req high: 1 cycle.
REQ-017 RD_ADDR: on bus_gnt=1 -> RD_DATA. RD_DATA: on bus_rvalid=1 capture bus_rdata into rd_data, pulse rd_valid one cycle, -> IDLE.
REQ-018 bus_rvalid outside RD_DATA and bus_gnt outside WR/RD_ADDR SHALL be ignored.
REQ-019 Simultaneous push and pop in non-full FIFO SHALL both occur; count unchanged; pointers wrap modulo WBUF_DEPTH.
REQ-020 wbuf_empty SHALL be 1 when FIFO count is 0 and state is not WR.
REQ-021 rd_data SHALL hold its last value until next capture.

Reset
REQ-022 i_rst low SHALL immediately clear state to IDLE, FIFO count and pointers to 0, discard buffered writes.
REQ-023 Reset values: bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_be 0, rd_data 0, rd_valid 0, bus_err 0, wbuf_empty 1; busy follows REQ-009.
REQ-024 Reset mid-transaction SHALL drop bus_req in the same cycle, without waiting for bus_gnt/bus_rvalid.

Configuration
REQ-025 Macro BUS_TIMEOUT_EN defined: cycle counter runs in WR, RD_ADDR, RD_DATA, cleared on state entry; reaching TIMEOUT_CYCLES forces -> IDLE with bus_err pulsed one cycle.
REQ-026 On timeout in WR the head entry SHALL be popped and discarded; in RD_ADDR/RD_DATA rd_data=0 and rd_valid pulses with bus_err.
REQ-027 Macro BUS_TIMEOUT_EN undefined: no counter, FSM waits indefinitely, bus_err tied 0.

Verification
REQ-028 SW: addr 0x1003, data 0xA5A5_1234, be 4'hF, bus_gnt immediate -> bus_addr 0x1000, bus_we 1, bus_be 4'hF, one cycle after push; FIFO empty after gnt.
REQ-029 Three back-to-back writes, depth 2, bus_gnt held 0 -> busy=1 on third; after gnt released, writes appear on bus in order.
REQ-030 Write to 0x20 then rd_req addr 0x24, bus_rdata 0xCAFE_F00D with 2-cycle rvalid delay -> write granted first, then read; rd_valid one cycle, rd_data 0xCAFE_F00D.
REQ-031 i_rst low during RD_DATA -> bus_req 0, rd_valid 0, wbuf_empty 1 immediately; no stale rd_valid after release.
REQ-032 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_gnt never -> bus_err pulse after 8 cycles in WR, entry discarded, wbuf_empty 1.
REQ-033 Push and pop same cycle with count 1 -> count stays 1; pointer wrap after 5 writes verified by order on bus.
